// File: rtl/ram_bank_pkg.sv
// Shared ram_bank geometry plus the round-robin helpers used by the arbiter slice.
// Requester vectors are padded to MAX_REQ so the helpers stay parameter-free.
package ram_bank_pkg;
    localparam int ADDR_BIT   = 3;
    localparam int DATA_BIT   = 16;
    localparam int MEM_HEIGHT = 8;
    localparam int MAX_REQ    = 8;

    // First set bit of req at or above ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input int ptr, input int n);
        logic [MAX_REQ-1:0] g;
        logic               found;
        int                 idx;
        logic [2:0]         idx3;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                idx3 = idx[2:0];
                if (!found && req[idx3]) begin
                    g[idx3] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
        return g;
    endfunction

    function automatic int oh2idx(input logic [MAX_REQ-1:0] oh);
        int r;
        r = 0;
        for (int k = 0; k < MAX_REQ; k++)
            if (oh[k]) r = k;
        return r;
    endfunction
endpackage

// File: rtl/ram_bank_arbiter_if.sv
// Requester handshakes and ram_bank pins of the shared bank arbiter.
// master = requesters plus the RAM, slave = the arbiter.
interface ram_bank_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_BIT = ram_bank_pkg::ADDR_BIT,
    parameter int DATA_BIT = ram_bank_pkg::DATA_BIT
);
    logic [NUM_REQ-1:0]               wr_valid;
    logic [NUM_REQ-1:0]               wr_ready;
    logic [NUM_REQ-1:0][ADDR_BIT-1:0] wr_addr;
    logic [NUM_REQ-1:0][DATA_BIT-1:0] wr_data;
    logic [NUM_REQ-1:0]               rd_valid;
    logic [NUM_REQ-1:0]               rd_ready;
    logic [NUM_REQ-1:0][ADDR_BIT-1:0] rd_addr;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [DATA_BIT-1:0]              rsp_data;
    logic                             ram_en;
    logic                             ram_we;
    logic                             ram_re;
    logic [ADDR_BIT-1:0]              ram_addr_w;
    logic [DATA_BIT-1:0]              ram_d_w;
    logic [ADDR_BIT-1:0]              ram_addr_r;
    logic [DATA_BIT-1:0]              ram_d_r;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_d_r,
        input  wr_ready, rd_ready, rsp_valid, rsp_data,
        input  ram_en, ram_we, ram_re, ram_addr_w, ram_d_w, ram_addr_r
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_d_r,
        output wr_ready, rd_ready, rsp_valid, rsp_data,
        output ram_en, ram_we, ram_re, ram_addr_w, ram_d_w, ram_addr_r
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from req and pointer, pointer moves past
// the winner. en gates both the grant and the pointer update.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_BIT-1:0] ptr
);
    import ram_bank_pkg::MAX_REQ;
    import ram_bank_pkg::rr_pick;
    import ram_bank_pkg::oh2idx;

    logic [PTR_BIT-1:0] ptr_q, ptr_d;
    logic [MAX_REQ-1:0] req_x, gnt_x;
    int                 nxt;

    always_comb begin
        req_x              = '0;
        req_x[NUM_REQ-1:0] = req;
        // Held low through reset so nothing issues to the RAM while rst is high.
        gnt_x = (en && !rst) ? rr_pick(req_x, int'(ptr_q), NUM_REQ) : '0;
        gnt   = gnt_x[NUM_REQ-1:0];
    end

    always_comb begin
        ptr_d = ptr_q;
        nxt   = oh2idx(gnt_x) + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        if (|gnt_x) ptr_d = PTR_BIT'(nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/ram_bank_arbiter.sv
// Shares one 2-port ram_bank between NUM_REQ requesters: independent write and read
// round-robin arbiters, same-address read hold-off, and 1-cycle response routing.
module ram_bank_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_BIT = ram_bank_pkg::ADDR_BIT,
    parameter int DATA_BIT = ram_bank_pkg::DATA_BIT,
    parameter int PTR_BIT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    ram_bank_arbiter_if.slave  bus
);
    import ram_bank_pkg::MAX_REQ;
    import ram_bank_pkg::rr_pick;
    import ram_bank_pkg::oh2idx;

    logic [NUM_REQ-1:0]  wr_gnt, rd_gnt, rsp_valid;
    logic [PTR_BIT-1:0]  wr_ptr, rd_ptr;
    logic [MAX_REQ-1:0]  rd_req_x, rd_cand_x, rd_gnt_x;
    logic [ADDR_BIT-1:0] addr_w, addr_r, rd_cand_addr;
    logic [DATA_BIT-1:0] d_w;
    logic                hazard;
    logic                rsp_vld_q;
    logic [PTR_BIT-1:0]  rsp_tag_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_BIT(PTR_BIT)) u_wr_arb (
        .clk(clk), .rst(rst), .req(bus.wr_valid), .en(1'b1), .gnt(wr_gnt), .ptr(wr_ptr)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_BIT(PTR_BIT)) u_rd_arb (
        .clk(clk), .rst(rst), .req(bus.rd_valid), .en(!hazard), .gnt(rd_gnt), .ptr(rd_ptr)
    );

    // The read that would win this cycle, found ahead of the grant so a clash with
    // the write address can suppress it; the write lands first, the read follows.
    always_comb begin
        rd_req_x              = '0;
        rd_req_x[NUM_REQ-1:0] = bus.rd_valid;
        rd_cand_x             = rr_pick(rd_req_x, int'(rd_ptr), NUM_REQ);
        rd_cand_addr          = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (rd_cand_x[i]) rd_cand_addr = rd_cand_addr | bus.rd_addr[i];
        hazard = (|wr_gnt) && (|rd_cand_x) && (rd_cand_addr == addr_w);
    end

    always_comb begin
        addr_w = '0;
        d_w    = '0;
        addr_r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                addr_w = addr_w | bus.wr_addr[i];
                d_w    = d_w    | bus.wr_data[i];
            end
            if (rd_gnt[i]) addr_r = addr_r | bus.rd_addr[i];
        end
    end

    always_comb begin
        rd_gnt_x              = '0;
        rd_gnt_x[NUM_REQ-1:0] = rd_gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q <= 1'b0;
            rsp_tag_q <= '0;
        end else begin
            rsp_vld_q <= |rd_gnt;
            rsp_tag_q <= PTR_BIT'(oh2idx(rd_gnt_x));
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] = rsp_vld_q && (int'(rsp_tag_q) == i);
    end

    assign bus.wr_ready   = wr_gnt;
    assign bus.rd_ready   = rd_gnt;
    assign bus.ram_we     = |wr_gnt;
    assign bus.ram_re     = |rd_gnt;
    assign bus.ram_en     = (|wr_gnt) | (|rd_gnt);
    assign bus.ram_addr_w = addr_w;
    assign bus.ram_d_w    = d_w;
    assign bus.ram_addr_r = addr_r;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = bus.ram_d_r;

    a_wr_ptr_range: assert property (@(posedge clk) disable iff (rst) int'(wr_ptr) < NUM_REQ);
    a_rd_ptr_range: assert property (@(posedge clk) disable iff (rst) int'(rd_ptr) < NUM_REQ);
endmodule

// File: tb/tb_ram_bank_arbiter.sv
// Directed bench for ram_bank_arbiter with NUM_REQ=2 and a behavioural 8x16 ram_bank.
module tb_ram_bank_arbiter;
    import ram_bank_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ram_bank_arbiter_if #(.NUM_REQ(2)) bus();

    ram_bank_arbiter #(.NUM_REQ(2), .ADDR_BIT(ADDR_BIT), .DATA_BIT(DATA_BIT), .PTR_BIT(1)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    // ram_bank: write port and registered read port
    logic [DATA_BIT-1:0] mem [MEM_HEIGHT];
    initial for (int i = 0; i < MEM_HEIGHT; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr_w] <= bus.ram_d_w;
        if (bus.ram_re) bus.ram_d_r <= mem[bus.ram_addr_r];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_valid = '0;
        bus.rd_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;

        // reset with every requester asking
        rst = 1'b1;
        bus.wr_valid = 2'b11; bus.rd_valid = 2'b11;
        bus.wr_addr[0] = 3'd0; bus.wr_addr[1] = 3'd1;
        bus.wr_data[0] = 16'h11; bus.wr_data[1] = 16'h22;
        bus.rd_addr[0] = 3'd4; bus.rd_addr[1] = 3'd5;
        @(negedge clk);
        chk("rst_wr_ready", bus.wr_ready, 2'b00);
        chk("rst_rd_ready", bus.rd_ready, 2'b00);
        chk("rst_ram_en", bus.ram_en, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("first_wr_gnt", bus.wr_ready, 2'b01);
        chk("first_rd_gnt", bus.rd_ready, 2'b01);
        chk("first_ram_en", bus.ram_en, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("first_rsp", bus.rsp_valid, 2'b01);

        // write contention: grants alternate
        do_reset();
        bus.wr_valid = 2'b11;
        bus.wr_addr[0] = 3'd0; bus.wr_addr[1] = 3'd1;
        bus.wr_data[0] = 16'h0A; bus.wr_data[1] = 16'h0B;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wc_gnt", bus.wr_ready, (k % 2) ? 2'b10 : 2'b01);
            chk("wc_d_w", bus.ram_d_w, (k % 2) ? 16'h0B : 16'h0A);
            chk("wc_addr_w", bus.ram_addr_w, (k % 2) ? 3'd1 : 3'd0);
            tick();
        end
        idle();

        // fill addr i with i from requester 1, read back from requester 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.wr_valid = 2'b10;
            bus.wr_addr[1] = 3'(i);
            bus.wr_data[1] = 16'(i);
            @(negedge clk);
            chk("fill_gnt", bus.wr_ready, 2'b10);
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            bus.rd_valid = 2'b01;
            bus.rd_addr[0] = 3'(i);
            @(negedge clk);
            chk("rb_gnt", bus.rd_ready, 2'b01);
            if (i > 0) begin
                chk("rb_rsp_valid", bus.rsp_valid, 2'b01);
                chk("rb_rsp_data", bus.rsp_data, 32'(i - 1));
            end
            tick();
        end
        idle();
        @(negedge clk);
        chk("rb_last_valid", bus.rsp_valid, 2'b01);
        chk("rb_last_data", bus.rsp_data, 16'd7);
        tick();
        @(negedge clk);
        chk("rb_drain", bus.rsp_valid, 2'b00);

        // interleaved reads: req0 addr 3, req1 addr 5
        do_reset();
        bus.rd_valid = 2'b11;
        bus.rd_addr[0] = 3'd3; bus.rd_addr[1] = 3'd5;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("il_gnt", bus.rd_ready, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) begin
                chk("il_rsp_valid", bus.rsp_valid, ((k - 1) % 2) ? 2'b10 : 2'b01);
                chk("il_rsp_data", bus.rsp_data, ((k - 1) % 2) ? 16'd5 : 16'd3);
            end
            tick();
        end
        idle();

        // same-address hazard: read held one cycle, returns new data
        do_reset();
        bus.wr_valid = 2'b01; bus.wr_addr[0] = 3'd3; bus.wr_data[0] = 16'd10;
        bus.rd_valid = 2'b10; bus.rd_addr[1] = 3'd3;
        @(negedge clk);
        chk("hz_wr_gnt", bus.wr_ready, 2'b01);
        chk("hz_rd_held", bus.rd_ready, 2'b00);
        chk("hz_ram_re", bus.ram_re, 1'b0);
        tick();
        bus.wr_valid = 2'b00;
        @(negedge clk);
        chk("hz_rd_gnt", bus.rd_ready, 2'b10);
        chk("hz_addr_r", bus.ram_addr_r, 3'd3);
        chk("hz_no_rsp", bus.rsp_valid, 2'b00);
        tick();
        idle();
        @(negedge clk);
        chk("hz_rsp_valid", bus.rsp_valid, 2'b10);
        chk("hz_rsp_data", bus.rsp_data, 16'd10);

        // one requester writes and reads different addresses together
        do_reset();
        bus.wr_valid = 2'b01; bus.wr_addr[0] = 3'd2; bus.wr_data[0] = 16'h55;
        bus.rd_valid = 2'b01; bus.rd_addr[0] = 3'd5;
        @(negedge clk);
        chk("dual_wr_gnt", bus.wr_ready, 2'b01);
        chk("dual_rd_gnt", bus.rd_ready, 2'b01);
        tick();
        idle();
        @(negedge clk);
        chk("dual_rsp_valid", bus.rsp_valid, 2'b01);
        chk("dual_rsp_data", bus.rsp_data, 16'd5);

        // reset between read issue and response
        do_reset();
        bus.wr_valid = 2'b01; bus.wr_addr[0] = 3'd6; bus.wr_data[0] = 16'h66;
        bus.rd_valid = 2'b01; bus.rd_addr[0] = 3'd7;
        @(negedge clk);
        chk("mr_rd_gnt", bus.rd_ready, 2'b01);
        tick();
        rst = 1'b1;
        idle();
        #1;
        chk("mr_rsp_dropped", bus.rsp_valid, 2'b00);
        chk("mr_rd_ready", bus.rd_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        bus.wr_valid = 2'b11; bus.rd_valid = 2'b11;
        bus.wr_addr[0] = 3'd0; bus.wr_addr[1] = 3'd1;
        bus.rd_addr[0] = 3'd4; bus.rd_addr[1] = 3'd5;
        #1;
        chk("mr_wr_ptr0", bus.wr_ready, 2'b01);
        chk("mr_rd_ptr0", bus.rd_ready, 2'b01);
        chk("mr_rsp_idle", bus.rsp_valid, 2'b00);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_bank_arbiter.md
Name: ram_bank_arbiter

Overview:
Shares one ram_bank (separate write and read ports, 8x16) between NUM_REQ requesters.
Two independent round-robin arbiters are used: one grants a single write per cycle, the other a single read per cycle.
Drives the ram_bank control and address/data pins directly.
Routes registered read data back to the issuing requester one cycle after issue.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_BIT, 3, ram_bank address width
DATA_BIT, 16, ram_bank data width
PTR_BIT, 1, priority pointer width, must equal ceil(log2(NUM_REQ))

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
wr_valid  input  NUM_REQ  per-requester write request
wr_ready  output  NUM_REQ  one-hot write grant; transfer when valid&&ready
wr_addr  input  NUM_REQ*ADDR_BIT  packed write addresses, requester i at [i*ADDR_BIT +: ADDR_BIT]
wr_data  input  NUM_REQ*DATA_BIT  packed write data
rd_valid  input  NUM_REQ  per-requester read request
rd_ready  output  NUM_REQ  one-hot read grant
rd_addr  input  NUM_REQ*ADDR_BIT  packed read addresses
rsp_valid  output  NUM_REQ  one-hot read-response strobe
rsp_data  output  DATA_BIT  read data, meaningful only when any rsp_valid bit is set
ram_en  output  1  to ram_bank en
ram_we  output  1  to ram_bank we
ram_re  output  1  to ram_bank re
ram_addr_w  output  ADDR_BIT  to ram_bank addr_w
ram_d_w  output  DATA_BIT  to ram_bank d_w
ram_addr_r  output  ADDR_BIT  to ram_bank addr_r
ram_d_r  input  DATA_BIT  from ram_bank d_r; registered, valid the cycle after re

Behaviour:
- Reset (async): wr_ptr=0, rd_ptr=0, rsp_valid=0, rsp_tag=0. While rst is high, wr_ready, rd_ready, ram_we, ram_re and ram_en are 0.
- Grants are combinational from valid and pointer in the same cycle. No requester needs to wait for ready before asserting valid. A requester must hold valid, addr and data stable until ready.
- Round-robin search starts at the pointer index and proceeds upward with wrap-around. The first valid index found is granted.
- On a grant to index g, the pointer becomes g+1, wrapping NUM_REQ-1 to 0. With no grant, the pointer holds.
- Starvation bound: a requester holding valid is granted within NUM_REQ cycles on its port.
- Write issue: ram_we=1, ram_addr_w and ram_d_w are muxed from the granted requester. With no write grant, ram_we=0 and addr/data are don't-care (drive 0).
- Read issue: ram_re=1, ram_addr_r is muxed from the granted requester.
- ram_en = ram_we | ram_re.
- Read latency is exactly 1 cycle.
  - At the issue edge, rsp_valid is registered to onehot(g) and rsp_tag to g.
  - In the next cycle, rsp_data = ram_d_r.
  - Back-to-back reads produce back-to-back responses.
  - No backpressure on responses: requesters must accept them.
- Write/read same-address hazard: if both grants exist in a cycle and the candidate read address equals ram_addr_w, the read is withheld.
  - rd_ready=0 and ram_re=0; rd_ptr holds.
  - The write proceeds.
  - The read is granted next cycle (if still requested) and returns the newly written data.
- A requester may have a write and a read granted in the same cycle on different addresses.
- Reset mid-operation: a pending response is dropped (rsp_valid cleared asynchronously). An in-flight write may or may not land in the RAM.
- Width rule: pointer increment is modulo NUM_REQ, not 2^PTR_BIT; this matters for non-power-of-two NUM_REQ.

Decomposition:
- Package ram_bank_pkg holds ADDR_BIT=3, DATA_BIT=16 and MEM_HEIGHT=8, shared with ram_bank.
- Sub-module rr_arbiter (params NUM_REQ, PTR_BIT; ports clk, rst, req, en, gnt, ptr) is instantiated twice: write and read.
  - The en input gates both the grant and the pointer update; the read instance uses it for hazard suppression.
- The top level holds the muxes, hazard compare and response register.

Test Plan:
- Reset: assert rst with all valids high -> all ready=0, ram_en=0. Release -> requester 0 is granted first on both ports.
- Write contention: both wr_valid held 4 cycles, addr 0/1, data 0x0A/0x0B -> grants alternate 0,1,0,1; ram_d_w alternates to match.
- Read-back: write addrs 0..7 with data 0..7 from requester 1, then requester 0 reads 0..7 -> rsp_valid=01 one cycle after each grant, with rsp_data 0..7 in order.
- Interleaved reads: both requesters read addr 3 (value 3) and addr 5 (value 5) continuously -> rsp_valid toggles 01/10 every cycle, with matching data.
- Hazard: requester 0 writes addr 3 data 10 while requester 1 reads addr 3 -> rd_ready=00 that cycle. Read is granted next cycle; response is 10 two cycles after the write.
- Mid-read reset: pulse rst between a read issue and its response -> rsp_valid stays 0, pointers return to 0.
